writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue_pkg.sv | 12 +
 rtl/writeback_queue_load_align.sv | 33 +++
 rtl/writeback_queue.sv | 146 ++++++++++++++
 tb/tb_writeback_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the writeback queue: opcode layout and load funct3 encodings.
package writeback_queue_pkg;

  localparam int OPCODE_WIDTH = 11;
  localparam int LOAD_WORD    = 1;

  localparam logic [2:0] FUNCT_LB  = 3'b000;
  localparam logic [2:0] FUNCT_LH  = 3'b001;
  localparam logic [2:0] FUNCT_LBU = 3'b100;
  localparam logic [2:0] FUNCT_LHU = 3'b101;

endpackage

// File: rtl/writeback_queue_load_align.sv
// Combinational load extraction: picks the byte/half addressed by the load offset
// and sign- or zero-extends it according to funct3.
module wb_load_align
  import writeback_queue_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] funct,
  input  logic [1:0]             addr_lsb,
  input  logic [DWIDTH-1:0]      data_load,
  output logic [DWIDTH-1:0]      data_aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data_load[{addr_lsb, 3'b000} +: 8];
  assign half_sel = data_load[{addr_lsb[1], 4'b0000} +: 16];

  // Extension select by funct3; unknown encodings pass the full word.
  always_comb begin
    data_aligned = data_load;
    case (funct)
      FUNCT_WIDTH'(FUNCT_LB):  data_aligned = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
      FUNCT_WIDTH'(FUNCT_LH):  data_aligned = {{(DWIDTH-16){half_sel[15]}}, half_sel};
      FUNCT_WIDTH'(FUNCT_LBU): data_aligned = {{(DWIDTH-8){1'b0}}, byte_sel};
      FUNCT_WIDTH'(FUNCT_LHU): data_aligned = {{(DWIDTH-16){1'b0}}, half_sel};
      default:                 data_aligned = data_load;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// Writeback FIFO between execute/memory and the register file. Entries are formatted
// at push time so the head drives the register file directly.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3,
  parameter int DEPTH       = 2
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wb_i_valid,
  output logic                    wb_o_ready,
  input  logic [OPCODE_WIDTH-1:0] wb_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  wb_i_funct,
  input  logic [1:0]              wb_i_addr_lsb,
  input  logic [DWIDTH-1:0]       wb_i_data_load,
  input  logic [DWIDTH-1:0]       wb_i_rd_data,
  input  logic [AWIDTH-1:0]       wb_i_rd_addr,
  input  logic                    wb_i_we_rd,
  input  logic [PC_WIDTH-1:0]     wb_i_pc,
  input  logic                    wb_i_change_pc,
  input  logic                    wb_i_flush,
  output logic                    wb_o_valid,
  input  logic                    wb_i_ready,
  output logic                    wb_o_we_rd,
  output logic [AWIDTH-1:0]       wb_o_rd_addr,
  output logic [DWIDTH-1:0]       wb_o_rd_data,
  output logic [PC_WIDTH-1:0]     wb_o_next_pc,
  output logic                    wb_o_change_pc,
  output logic                    wb_o_flush
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic                we_rd;
    logic [AWIDTH-1:0]   rd_addr;
    logic [DWIDTH-1:0]   rd_data;
    logic [PC_WIDTH-1:0] next_pc;
    logic                change_pc;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic [DWIDTH-1:0]  load_data;
  logic               full;
  logic               push;
  logic               pop;
  logic               flush_q;

  wb_load_align #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_load_align (
    .funct        (wb_i_funct),
    .addr_lsb     (wb_i_addr_lsb),
    .data_load    (wb_i_data_load),
    .data_aligned (load_data)
  );

  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign wb_o_ready = wb_rst && !full && !wb_i_flush;
  assign wb_o_valid = (count != '0);
  assign push       = wb_i_valid && wb_o_ready;
  assign pop        = wb_o_valid && wb_i_ready;

  // Format the incoming entry; x0 never gets a write enable.
  always_comb begin
    new_entry           = '0;
    new_entry.we_rd     = wb_i_we_rd && (wb_i_rd_addr != '0);
    new_entry.rd_addr   = wb_i_rd_addr;
    new_entry.next_pc   = wb_i_pc + PC_WIDTH'(4);
    new_entry.change_pc = wb_i_change_pc;
    if (wb_i_opcode[LOAD_WORD]) begin
      new_entry.rd_data = load_data;
    end else if (wb_i_we_rd) begin
      new_entry.rd_data = wb_i_rd_data;
    end else begin
      new_entry.rd_data = '0;
    end
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge wb_clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointer/count bookkeeping; flush beats push and pop.
  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= wb_i_flush;
      if (wb_i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign wb_o_flush = flush_q;

  // Head fields are forced to zero whenever the queue is empty.
  always_comb begin
    wb_o_we_rd     = 1'b0;
    wb_o_rd_addr   = '0;
    wb_o_rd_data   = '0;
    wb_o_next_pc   = '0;
    wb_o_change_pc = 1'b0;
    if (wb_o_valid) begin
      wb_o_we_rd     = mem[rd_ptr].we_rd;
      wb_o_rd_addr   = mem[rd_ptr].rd_addr;
      wb_o_rd_data   = mem[rd_ptr].rd_data;
      wb_o_next_pc   = mem[rd_ptr].next_pc;
      wb_o_change_pc = mem[rd_ptr].change_pc;
    end else begin
      wb_o_we_rd     = 1'b0;
      wb_o_rd_addr   = '0;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 2;

  logic                    wb_clk = 1'b0;
  logic                    wb_rst;
  logic                    wb_i_valid;
  logic                    wb_o_ready;
  logic [OPCODE_WIDTH-1:0] wb_i_opcode;
  logic [2:0]              wb_i_funct;
  logic [1:0]              wb_i_addr_lsb;
  logic [31:0]             wb_i_data_load;
  logic [31:0]             wb_i_rd_data;
  logic [4:0]              wb_i_rd_addr;
  logic                    wb_i_we_rd;
  logic [31:0]             wb_i_pc;
  logic                    wb_i_change_pc;
  logic                    wb_i_flush;
  logic                    wb_o_valid;
  logic                    wb_i_ready;
  logic                    wb_o_we_rd;
  logic [4:0]              wb_o_rd_addr;
  logic [31:0]             wb_o_rd_data;
  logic [31:0]             wb_o_next_pc;
  logic                    wb_o_change_pc;
  logic                    wb_o_flush;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] npc;
    logic        cpc;
  } ent_t;

  writeback_queue #(.DWIDTH(32), .AWIDTH(5), .PC_WIDTH(32), .FUNCT_WIDTH(3), .DEPTH(DEPTH)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_i_valid(wb_i_valid), .wb_o_ready(wb_o_ready),
    .wb_i_opcode(wb_i_opcode), .wb_i_funct(wb_i_funct), .wb_i_addr_lsb(wb_i_addr_lsb),
    .wb_i_data_load(wb_i_data_load), .wb_i_rd_data(wb_i_rd_data), .wb_i_rd_addr(wb_i_rd_addr),
    .wb_i_we_rd(wb_i_we_rd), .wb_i_pc(wb_i_pc), .wb_i_change_pc(wb_i_change_pc),
    .wb_i_flush(wb_i_flush), .wb_o_valid(wb_o_valid), .wb_i_ready(wb_i_ready),
    .wb_o_we_rd(wb_o_we_rd), .wb_o_rd_addr(wb_o_rd_addr), .wb_o_rd_data(wb_o_rd_data),
    .wb_o_next_pc(wb_o_next_pc), .wb_o_change_pc(wb_o_change_pc), .wb_o_flush(wb_o_flush)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic next_cycle();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_entry(input logic is_load, input logic [2:0] f, input logic [1:0] lsb,
                           input logic [31:0] ld, input logic [31:0] rd, input logic [4:0] a,
                           input logic we, input logic [31:0] pc, input logic cpc);
    logic [OPCODE_WIDTH-1:0] op;
    op = '0;
    if (is_load) op[LOAD_WORD] = 1'b1;
    else op[LOAD_WORD + 1] = 1'b1;
    wb_i_opcode = op; wb_i_funct = f; wb_i_addr_lsb = lsb; wb_i_data_load = ld;
    wb_i_rd_data = rd; wb_i_rd_addr = a; wb_i_we_rd = we; wb_i_pc = pc; wb_i_change_pc = cpc;
  endtask

  // Empties the queue via a one-cycle flush and lets the flush echo settle.
  task automatic clear_queue();
    wb_i_valid = 1'b0; wb_i_ready = 1'b0; wb_i_flush = 1'b1;
    next_cycle();
    wb_i_flush = 1'b0;
    next_cycle();
  endtask

  // Reference: load formatting from funct3 rules using plain shifts and masks.
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] lsb, input logic [31:0] ld);
    logic [31:0] b, h;
    b = (ld >> (8 * lsb)) & 32'h0000_00FF;
    h = (ld >> (16 * lsb[1])) & 32'h0000_FFFF;
    case (f)
      3'b000:  return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return ld;
    endcase
  endfunction

  task automatic test_reset();
    wb_rst = 1'b0; wb_i_valid = 1'b1; wb_i_ready = 1'b1; wb_i_flush = 1'b0;
    set_entry(1'b0, 3'd0, 2'd0, 32'h0, 32'h1234, 5'd3, 1'b1, 32'h100, 1'b1);
    next_cycle();
    next_cycle();
    vectors++;
    if ({wb_o_ready, wb_o_valid, wb_o_flush, wb_o_we_rd, wb_o_change_pc} !== 5'b0 ||
        wb_o_rd_addr !== 5'd0 || wb_o_rd_data !== 32'd0 || wb_o_next_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b flush=%b data=%h npc=%h, required all 0",
               wb_o_ready, wb_o_valid, wb_o_flush, wb_o_rd_data, wb_o_next_pc);
    end
    wb_i_valid = 1'b0; wb_i_ready = 1'b0;
    wb_rst = 1'b1;
    next_cycle();
    vectors++;
    if (wb_o_ready !== 1'b1 || wb_o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", wb_o_ready, wb_o_valid);
    end
  endtask

  task automatic test_lb();
    set_entry(1'b1, 3'b000, 2'b11, 32'h80FF_1234, 32'h5555_5555, 5'd7, 1'b1, 32'h40, 1'b0);
    wb_i_valid = 1'b1;
    vectors++;
    if (wb_o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lb_no_bypass: valid=%b, required 0", wb_o_valid);
    end
    next_cycle();
    wb_i_valid = 1'b0;
    vectors++;
    if (wb_o_valid !== 1'b1 || wb_o_rd_data !== 32'hFFFF_FF80 || wb_o_rd_addr !== 5'd7 || wb_o_we_rd !== 1'b1) begin
      miscompares++;
      $display("FAIL lb_data: valid=%b data=%h addr=%0d we=%b, required 1 ffffff80 7 1",
               wb_o_valid, wb_o_rd_data, wb_o_rd_addr, wb_o_we_rd);
    end
    clear_queue();
  endtask

  task automatic test_lhu();
    set_entry(1'b1, 3'b101, 2'b10, 32'hBEEF_0000, 32'h0, 5'd9, 1'b1, 32'h80, 1'b0);
    wb_i_valid = 1'b1;
    next_cycle();
    wb_i_valid = 1'b0;
    vectors++;
    if (wb_o_rd_data !== 32'h0000_BEEF) begin
      miscompares++;
      $display("FAIL lhu_data: data=%h, required 0000beef", wb_o_rd_data);
    end
    clear_queue();
  endtask

  task automatic test_rd_zero();
    set_entry(1'b0, 3'b010, 2'b00, 32'h0, 32'd5, 5'd0, 1'b1, 32'h10, 1'b0);
    wb_i_valid = 1'b1;
    next_cycle();
    wb_i_valid = 1'b0;
    vectors++;
    if (wb_o_valid !== 1'b1 || wb_o_we_rd !== 1'b0 || wb_o_rd_data !== 32'd5) begin
      miscompares++;
      $display("FAIL rd_zero: valid=%b we=%b data=%h, required 1 0 5", wb_o_valid, wb_o_we_rd, wb_o_rd_data);
    end
    clear_queue();
  endtask

  task automatic test_pc_wrap();
    set_entry(1'b0, 3'b000, 2'b00, 32'h0, 32'hDEAD_BEEF, 5'd4, 1'b0, 32'hFFFF_FFFC, 1'b1);
    wb_i_valid = 1'b1;
    next_cycle();
    wb_i_valid = 1'b0;
    vectors++;
    if (wb_o_next_pc !== 32'd0 || wb_o_change_pc !== 1'b1 || wb_o_rd_data !== 32'd0 || wb_o_we_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL pc_wrap: npc=%h cpc=%b data=%h we=%b, required 0 1 0 0",
               wb_o_next_pc, wb_o_change_pc, wb_o_rd_data, wb_o_we_rd);
    end
    clear_queue();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic [31:0] vals [3];
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    wb_i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_entry(1'b0, 3'd0, 2'd0, 32'h0, vals[k], 5'd1, 1'b1, 32'h0, 1'b0);
      wb_i_valid = 1'b1;
      next_cycle();
    end
    set_entry(1'b0, 3'd0, 2'd0, 32'h0, vals[2], 5'd1, 1'b1, 32'h0, 1'b0);
    vectors++;
    if (wb_o_ready !== 1'b0 || wb_o_rd_data !== vals[0]) begin
      miscompares++;
      $display("FAIL full_hold: ready=%b head=%h, required 0 a", wb_o_ready, wb_o_rd_data);
    end
    next_cycle();
    vectors++;
    if (wb_o_ready !== 1'b0 || wb_o_rd_data !== vals[0]) begin
      miscompares++;
      $display("FAIL full_hold2: ready=%b head=%h, required 0 a", wb_o_ready, wb_o_rd_data);
    end
    wb_i_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic c_taken;
      c_taken = wb_i_valid && wb_o_ready;
      if (wb_o_valid && wb_i_ready) got.push_back(wb_o_rd_data);
      next_cycle();
      if (c_taken) wb_i_valid = 1'b0;
    end
    wb_i_ready = 1'b0;
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL order_count: popped %0d entries, required 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got[k] !== vals[k]) begin
          miscompares++;
          $display("FAIL order_%0d: data=%h, required %h", k, got[k], vals[k]);
        end
      end
    end
    clear_queue();
  endtask

  task automatic test_flush();
    wb_i_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_entry(1'b0, 3'd0, 2'd0, 32'h0, 32'h100 + k, 5'd2, 1'b1, 32'h0, 1'b0);
      wb_i_valid = 1'b1;
      next_cycle();
    end
    wb_i_valid = 1'b1; wb_i_flush = 1'b1; wb_i_ready = 1'b1;
    vectors++;
    if (wb_o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: ready=%b, required 0", wb_o_ready);
    end
    next_cycle();
    wb_i_flush = 1'b0; wb_i_valid = 1'b0; wb_i_ready = 1'b0;
    vectors++;
    if (wb_o_valid !== 1'b0 || wb_o_flush !== 1'b1 || wb_o_rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_clear: valid=%b oflush=%b data=%h, required 0 1 0", wb_o_valid, wb_o_flush, wb_o_rd_data);
    end
    next_cycle();
    vectors++;
    if (wb_o_flush !== 1'b0 || wb_o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_echo_end: oflush=%b valid=%b, required 0 0", wb_o_flush, wb_o_valid);
    end
  endtask

  task automatic test_reset_mid();
    set_entry(1'b0, 3'd0, 2'd0, 32'h0, 32'h77, 5'd6, 1'b1, 32'h0, 1'b0);
    wb_i_valid = 1'b1; wb_i_ready = 1'b0;
    next_cycle();
    wb_i_valid = 1'b0;
    #2 wb_rst = 1'b0;
    #1;
    vectors++;
    if (wb_o_valid !== 1'b0 || wb_o_ready !== 1'b0 || wb_o_rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b ready=%b data=%h, required 0 0 0", wb_o_valid, wb_o_ready, wb_o_rd_data);
    end
    next_cycle();
    wb_rst = 1'b1;
    next_cycle();
    vectors++;
    if (wb_o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_after: valid=%b, required 0", wb_o_valid);
    end
  endtask

  task automatic test_random(input int n);
    ent_t q [$];
    ent_t h, e;
    logic prev_flush;
    logic push, pop;
    prev_flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (wb_o_valid !== (q.size() != 0) || wb_o_flush !== prev_flush) begin
        miscompares++;
        $display("FAIL rnd_status@%0d: valid=%b oflush=%b, required %b %b",
                 i, wb_o_valid, wb_o_flush, q.size() != 0, prev_flush);
      end
      h = (q.size() != 0) ? q[0] : '0;
      vectors++;
      if ({wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data, wb_o_next_pc, wb_o_change_pc} !== h) begin
        miscompares++;
        $display("FAIL rnd_head@%0d: we=%b addr=%0d data=%h npc=%h cpc=%b, required %b %0d %h %h %b",
                 i, wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data, wb_o_next_pc, wb_o_change_pc,
                 h.we, h.addr, h.data, h.npc, h.cpc);
      end
      set_entry($urandom_range(1), 3'($urandom_range(7)), 2'($urandom_range(3)), $urandom,
                $urandom, 5'($urandom_range(31) * $urandom_range(1)), $urandom_range(1),
                ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom_range(1));
      wb_i_valid = $urandom_range(3) != 0;
      wb_i_ready = $urandom_range(1);
      wb_i_flush = $urandom_range(15) == 0;
      #1;
      vectors++;
      if (wb_o_ready !== (q.size() < DEPTH && !wb_i_flush)) begin
        miscompares++;
        $display("FAIL rnd_ready@%0d: ready=%b, required %b", i, wb_o_ready, q.size() < DEPTH && !wb_i_flush);
      end
      push = wb_i_valid && q.size() < DEPTH && !wb_i_flush;
      pop  = q.size() != 0 && wb_i_ready;
      e.we   = wb_i_we_rd && wb_i_rd_addr != 5'd0;
      e.addr = wb_i_rd_addr;
      e.data = wb_i_opcode[LOAD_WORD] ? ref_load(wb_i_funct, wb_i_addr_lsb, wb_i_data_load)
                                      : (wb_i_we_rd ? wb_i_rd_data : 32'd0);
      e.npc  = wb_i_pc + 32'd4;
      e.cpc  = wb_i_change_pc;
      prev_flush = wb_i_flush;
      if (wb_i_flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      @(posedge wb_clk);
      #1;
    end
    clear_queue();
  endtask

  initial begin
    wb_rst = 1'b0; wb_i_valid = 1'b0; wb_i_ready = 1'b0; wb_i_flush = 1'b0;
    set_entry(1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0);
    #1;
    test_reset();
    test_lb();
    test_lhu();
    test_rd_zero();
    test_pc_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
